// File: rtl/spi2_pkg.sv
// spi2_pkg: word width, command opcodes and word type shared across the spi2 link.
package spi2_pkg;
  localparam int SPI2_WORD_W = 16;
  localparam logic [7:0] CMD_REG_RD = 8'h80;
  localparam logic [15:0] CMD_MEM_RD = 16'hC000;
  localparam logic [15:0] CMD_MEM_WR = 16'hC100;
  localparam logic [15:0] CMD_BURST = 16'hD000;
  localparam logic [15:0] CMD_MIX_RD = 16'h9000;
  localparam logic [15:0] CMD_MIX_WR = 16'h9100;
  localparam logic [15:0] CMD_RUN = 16'h1001;
  typedef logic [SPI2_WORD_W-1:0] spi2_word_t;
endpackage

// File: rtl/spi2_sync_edge.sv
// spi2_sync_edge: multi-flop synchroniser with one history flop; tgl marks a change of q.
module spi2_sync_edge #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input logic clk,
  input logic rst,
  input logic d,
  output logic q,
  output logic tgl
);
  logic [STAGES:0] s;
  always_ff @(posedge clk)
    s <= rst ? {(STAGES + 1){RST_VAL}} : {s[STAGES-1:0], d};
  assign q = s[STAGES-1];
  assign tgl = s[STAGES] ^ s[STAGES-1];
endmodule

// File: rtl/spi2_slave_u16.sv
// spi2_slave_u16: oversampled SPI responder, MSB-first RX / LSB-first TX words.
// Define SPI2_RX_FIFO_EN to replace the single RX holding register with a FIFO.
import spi2_pkg::*;
module spi2_slave_u16 #(
  parameter int WORD_W = SPI2_WORD_W,
  parameter int SYNC_STAGES = 2,
  parameter int RX_FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  input logic spi_sck,
  input logic spi_cs,
  input logic spi_mosi,
  output logic spi_miso,
  output logic [WORD_W-1:0] rx_data,
  output logic rx_valid,
  input logic rx_ready,
  input logic [WORD_W-1:0] tx_data,
  input logic tx_valid,
  output logic tx_ready,
  output logic cs_active,
  output logic frame_start,
  output logic frame_end,
  output logic rx_overrun,
  output logic tx_underrun,
  input logic clr_flags
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam int BW = $clog2(WORD_W);
  localparam logic [BW-1:0] LAST = BW'(WORD_W - 1);
  localparam int AW = $clog2(SYNC_STAGES + 2);
  localparam logic [AW-1:0] ARM = AW'(SYNC_STAGES + 1);
  logic [0:0] state;
  logic sck_q, sck_tgl, cs_q, cs_tgl, armed, rise, fall, start, stop, load, pop;
  logic word_done, reload_pend, hold_full, ovr_set;
  logic [AW-1:0] arm_cnt;
  logic [BW-1:0] bit_cnt;
  logic [SYNC_STAGES-1:0] mosi_s;
  logic [WORD_W-1:0] rx_shift, tx_shift, hold_data;
  spi2_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .d(spi_sck), .q(sck_q), .tgl(sck_tgl)
  );
  spi2_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d(spi_cs), .q(cs_q), .tgl(cs_tgl)
  );
  // cs must be seen high on real samples after reset, so a reset inside a frame is not taken as a new frame
  assign armed = arm_cnt == ARM;
  assign start = state == IDLE && armed && cs_tgl && !cs_q;
  assign stop = state == SHIFT && cs_tgl && cs_q;
  assign rise = state == SHIFT && !cs_q && sck_tgl && sck_q;
  assign fall = state == SHIFT && !cs_q && sck_tgl && !sck_q;
  assign load = start || (fall && reload_pend);
  assign pop = rx_valid && rx_ready;
  assign tx_ready = !hold_full && !load;
  assign cs_active = !cs_q;
  assign spi_miso = state == SHIFT && tx_shift[0];
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      arm_cnt <= '0;
      mosi_s <= '0;
      bit_cnt <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
      word_done <= 1'b0;
      reload_pend <= 1'b0;
      frame_start <= 1'b0;
      frame_end <= 1'b0;
      rx_overrun <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      state <= start ? SHIFT : stop ? IDLE : state;
      arm_cnt <= armed ? arm_cnt : cs_q ? arm_cnt + 1'b1 : '0;
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], spi_mosi};
      bit_cnt <= (start || stop) ? '0 : rise ? (bit_cnt == LAST ? '0 : bit_cnt + 1'b1) : bit_cnt;
      rx_shift <= rise ? {rx_shift[WORD_W-2:0], mosi_s[SYNC_STAGES-1]} : rx_shift;
      word_done <= rise && bit_cnt == LAST;
      reload_pend <= (start || stop) ? 1'b0 : (rise && bit_cnt == LAST) ? 1'b1 : load ? 1'b0 : reload_pend;
      tx_shift <= load ? (hold_full ? hold_data : '0) : fall ? tx_shift >> 1 : tx_shift;
      hold_data <= (tx_valid && tx_ready) ? tx_data : hold_data;
      hold_full <= load ? 1'b0 : (tx_valid && tx_ready) ? 1'b1 : hold_full;
      frame_start <= start;
      frame_end <= stop;
      rx_overrun <= clr_flags ? 1'b0 : rx_overrun || ovr_set;
      tx_underrun <= clr_flags ? 1'b0 : tx_underrun || (load && !hold_full);
    end
`ifdef SPI2_RX_FIFO_EN
  localparam int PW = $clog2(RX_FIFO_DEPTH);
  logic [WORD_W-1:0] mem [RX_FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic full, wr;
  assign full = cnt == (PW + 1)'(RX_FIFO_DEPTH);
  assign wr = word_done && (!full || pop);
  assign ovr_set = word_done && full && !pop;
  assign rx_valid = cnt != '0;
  assign rx_data = rx_valid ? mem[rp] : '0;
  always_ff @(posedge clk)
    if (wr) mem[wp] <= rx_shift;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wr ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      cnt <= cnt + (PW + 1)'(wr) - (PW + 1)'(pop);
    end
`else
  // a pop in the same cycle frees the register for the arriving word
  assign ovr_set = word_done && rx_valid && !rx_ready;
  always_ff @(posedge clk)
    if (rst) begin
      rx_valid <= 1'b0;
      rx_data <= '0;
    end else if (word_done && (!rx_valid || pop)) begin
      rx_valid <= 1'b1;
      rx_data <= rx_shift;
    end else if (pop) rx_valid <= 1'b0;
`endif
endmodule
